// File: rtl/dice_pe_pkg.sv
// Shared definitions for the DICE processing element: ALU opcodes,
// pipe-stage record and fabric-wide limits.
package dice_pe_pkg;

  localparam int unsigned PE_DATA_W       = 32;
  localparam int unsigned PE_IDX_W        = 8;
  localparam int unsigned PE_MAX_ALU_PIPE = 3;

  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_SUB = 1;
  localparam int unsigned OP_AND = 2;
  localparam int unsigned OP_OR  = 3;
  localparam int unsigned OP_XOR = 4;
  localparam int unsigned OP_LT  = 5;
  localparam int unsigned OP_EQ  = 6;
  localparam int unsigned OP_MAC = 7;
  localparam int unsigned OP_SEL = 8;

  // Wide enough for any PE instance in the subsystem; narrower PEs zero-extend.
  typedef struct packed {
    logic [PE_DATA_W-1:0] data;
    logic                 pred;
    logic                 valid;
    logic                 wr_en;
    logic [PE_IDX_W-1:0]  wr_idx;
  } pe_stage_t;

endpackage

// File: rtl/dice_alu_w.sv
// Width-parametrised combinational ALU of the DICE PE. Compare ops drive the
// predicate; every other op passes the predicate operand through.
module dice_alu_w
  import dice_pe_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned OPCODE_W = 32
) (
  input  logic [DATA_W-1:0]   op_a,
  input  logic [DATA_W-1:0]   op_b,
  input  logic [DATA_W-1:0]   op_c,
  input  logic                op_p,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [DATA_W-1:0]   res,
  output logic                pred
);

  always_comb begin
    res  = '0;
    pred = op_p;
    case (opcode)
      OPCODE_W'(OP_ADD): res = op_a + op_b;
      OPCODE_W'(OP_SUB): res = op_a - op_b;
      OPCODE_W'(OP_AND): res = op_a & op_b;
      OPCODE_W'(OP_OR):  res = op_a | op_b;
      OPCODE_W'(OP_XOR): res = op_a ^ op_b;
      OPCODE_W'(OP_LT): begin
        pred   = op_a < op_b;
        res[0] = pred;
      end
      OPCODE_W'(OP_EQ): begin
        pred   = op_a == op_b;
        res[0] = pred;
      end
      OPCODE_W'(OP_MAC): res = op_a * op_b + op_c;
      OPCODE_W'(OP_SEL): res = op_p ? op_a : op_b;
      default: begin
        res  = '0;
        pred = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dice_pe_rf.sv
// DICE processing element: ALU, configurable result pipe and an indexed local
// register bank with per-entry valid bits.
module dice_pe_rf
  import dice_pe_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned OPCODE_W = 32,
  parameter int unsigned ALU_PIPE = 1,
  localparam int unsigned IDX_W   = ($clog2(NUM_REGS) > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   pe_in0,
  input  logic [DATA_W-1:0]   pe_in1,
  input  logic [DATA_W-1:0]   pe_in2,
  input  logic                pe_in3,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                out_sel,
  input  logic                alu_wr_en,
  input  logic [IDX_W-1:0]    alu_wr_idx,
  input  logic [DATA_W-1:0]   dff_in,
  input  logic                dff_wr_en,
  input  logic [IDX_W-1:0]    dff_wr_idx,
  input  logic [IDX_W-1:0]    t0_idx,
  input  logic [IDX_W-1:0]    t1_idx,
  input  logic                ctx_clear,
  output logic [DATA_W-1:0]   pe_out_t0,
  output logic                pe_out_t0_vld,
  output logic [DATA_W-1:0]   pe_out_t1,
  output logic                pe_out_t1_vld,
  output logic                pe_out_p0,
  output logic                pe_out_p0_vld,
  output logic                conflict_err,
  output logic                busy
);

  if (ALU_PIPE > PE_MAX_ALU_PIPE || NUM_REGS < 2 || DATA_W > PE_DATA_W || IDX_W > PE_IDX_W)
  begin : g_bad_cfg
    $error("dice_pe_rf: unsupported parameter combination");
  end

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return 32'(idx) < NUM_REGS;
  endfunction

  logic [DATA_W-1:0] alu_res;
  logic              alu_pred;
  pe_stage_t         issue;
  pe_stage_t         tail;
  logic [IDX_W-1:0]  tail_idx;

  dice_alu_w #(
    .DATA_W   (DATA_W),
    .OPCODE_W (OPCODE_W)
  ) u_alu (
    .op_a   (pe_in0),
    .op_b   (pe_in1),
    .op_c   (pe_in2),
    .op_p   (pe_in3),
    .opcode (opcode),
    .res    (alu_res),
    .pred   (alu_pred)
  );

  always_comb begin
    issue        = '0;
    issue.data   = PE_DATA_W'(alu_res);
    issue.pred   = alu_pred;
    issue.valid  = in_valid;
    issue.wr_en  = alu_wr_en;
    issue.wr_idx = PE_IDX_W'(alu_wr_idx);
  end

  if (ALU_PIPE == 0) begin : g_comb
    assign tail = issue;
    assign busy = 1'b0;
  end else begin : g_pipe
    pe_stage_t [ALU_PIPE-1:0] stage_q, stage_d;

    always_comb begin
      stage_d[0] = ctx_clear ? '0 : issue;
      for (int unsigned i = 1; i < ALU_PIPE; i++) begin
        stage_d[i] = ctx_clear ? '0 : stage_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) stage_q <= '0;
      else        stage_q <= stage_d;
    end

    always_comb begin
      busy = 1'b0;
      for (int unsigned i = 0; i < ALU_PIPE; i++) begin
        busy = busy | stage_q[i].valid;
      end
    end

    assign tail = stage_q[ALU_PIPE-1];
  end

  assign tail_idx = tail.wr_idx[IDX_W-1:0];

  logic unused_tail;
  assign unused_tail = ^{tail.data, tail.wr_idx};

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] rvld_q, rvld_d;
  logic                conflict_q, conflict_d;
  logic                commit, dff_ok;

  // The ALU commit is applied after the dff write so it overwrites on a clash.
  always_comb begin
    regs_d     = regs_q;
    rvld_d     = rvld_q;
    conflict_d = conflict_q;
    commit     = tail.valid && tail.wr_en && in_range(tail_idx);
    dff_ok     = dff_wr_en && in_range(dff_wr_idx);
    if (dff_ok) begin
      regs_d[dff_wr_idx] = dff_in;
      rvld_d[dff_wr_idx] = 1'b1;
    end
    if (commit) begin
      regs_d[tail_idx] = tail.data[DATA_W-1:0];
      rvld_d[tail_idx] = 1'b1;
    end
    if (commit && dff_ok && (tail_idx == dff_wr_idx)) conflict_d = 1'b1;
    if (ctx_clear) begin
      regs_d     = '{default: '0};
      rvld_d     = '0;
      conflict_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q     <= '{default: '0};
      rvld_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      rvld_q     <= rvld_d;
      conflict_q <= conflict_d;
    end
  end

  always_comb begin
    pe_out_t0     = '0;
    pe_out_t0_vld = 1'b0;
    if (in_range(t0_idx)) begin
      pe_out_t0     = regs_q[t0_idx];
      pe_out_t0_vld = rvld_q[t0_idx];
    end
    pe_out_t1     = tail.data[DATA_W-1:0];
    pe_out_t1_vld = tail.valid;
    if (out_sel) begin
      pe_out_t1     = '0;
      pe_out_t1_vld = 1'b0;
      if (in_range(t1_idx)) begin
        pe_out_t1     = regs_q[t1_idx];
        pe_out_t1_vld = rvld_q[t1_idx];
      end
    end
  end

  assign pe_out_p0     = tail.pred;
  assign pe_out_p0_vld = tail.valid;
  assign conflict_err  = conflict_q;

endmodule

// File: tb/tb_dice_pe_rf.sv
// Directed bench for dice_pe_rf: four configurations driven from one shared
// stimulus stream, each checked where its parameters matter.
module tb_dice_pe_rf;
  import dice_pe_pkg::*;

  localparam int P1 = 0;  // ALU_PIPE=1, NUM_REGS=4
  localparam int P3 = 1;  // ALU_PIPE=3, NUM_REGS=4
  localparam int P0 = 2;  // ALU_PIPE=0, NUM_REGS=4
  localparam int N3 = 3;  // ALU_PIPE=1, NUM_REGS=3
  localparam int unsigned CFG_PIPE [4] = '{1, 3, 0, 1};
  localparam int unsigned CFG_NREG [4] = '{4, 4, 4, 3};

  logic        clk = 1'b0;
  logic        rst_n, in_valid, pe_in3, out_sel, alu_wr_en, dff_wr_en, ctx_clear;
  logic [31:0] pe_in0, pe_in1, pe_in2, opcode, dff_in;
  logic [1:0]  alu_wr_idx, dff_wr_idx, t0_idx, t1_idx;

  logic [31:0] t0 [4];
  logic [31:0] t1 [4];
  logic        t0v [4];
  logic        t1v [4];
  logic        p0 [4];
  logic        p0v [4];
  logic        cerr [4];
  logic        busy [4];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dice_pe_rf #(
      .DATA_W   (32),
      .NUM_REGS (CFG_NREG[g]),
      .OPCODE_W (32),
      .ALU_PIPE (CFG_PIPE[g])
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .pe_in0        (pe_in0),
      .pe_in1        (pe_in1),
      .pe_in2        (pe_in2),
      .pe_in3        (pe_in3),
      .opcode        (opcode),
      .out_sel       (out_sel),
      .alu_wr_en     (alu_wr_en),
      .alu_wr_idx    (alu_wr_idx),
      .dff_in        (dff_in),
      .dff_wr_en     (dff_wr_en),
      .dff_wr_idx    (dff_wr_idx),
      .t0_idx        (t0_idx),
      .t1_idx        (t1_idx),
      .ctx_clear     (ctx_clear),
      .pe_out_t0     (t0[g]),
      .pe_out_t0_vld (t0v[g]),
      .pe_out_t1     (t1[g]),
      .pe_out_t1_vld (t1v[g]),
      .pe_out_p0     (p0[g]),
      .pe_out_p0_vld (p0v[g]),
      .conflict_err  (cerr[g]),
      .busy          (busy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    alu_wr_en = 1'b0;
    dff_wr_en = 1'b0;
    ctx_clear = 1'b0;
    out_sel   = 1'b0;
    pe_in3    = 1'b0;
  endtask

  task automatic issue(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic wr, input logic [1:0] idx);
    in_valid   = 1'b1;
    opcode     = op;
    pe_in0     = a;
    pe_in1     = b;
    pe_in2     = '0;
    alu_wr_en  = wr;
    alu_wr_idx = idx;
  endtask

  task automatic dffw(input logic [1:0] idx, input logic [31:0] d);
    dff_wr_en  = 1'b1;
    dff_wr_idx = idx;
    dff_in     = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    opcode = OP_ADD; pe_in0 = '0; pe_in1 = '0; pe_in2 = '0;
    alu_wr_idx = '0; dff_in = '0; dff_wr_idx = '0; t0_idx = '0; t1_idx = '0;

    // Reset state
    nxt(); nxt(); mid();
    chk("rst_t0",   t0[P1], 0);
    chk("rst_t0v",  32'(t0v[P1]), 0);
    chk("rst_t1",   t1[P1], 0);
    chk("rst_t1v",  32'(t1v[P1]), 0);
    chk("rst_p0v",  32'(p0v[P1]), 0);
    chk("rst_busy", 32'(busy[P3]), 0);
    chk("rst_cerr", 32'(cerr[P1]), 0);
    in_valid = 1'b1; pe_in0 = 2; pe_in1 = 3;
    #1;
    chk("rst_comb_t1",  t1[P0], 5);
    chk("rst_comb_t1v", 32'(t1v[P0]), 1);
    idle();
    nxt();
    rst_n = 1'b1;

    // Basic add, ALU_PIPE=1
    issue(OP_ADD, 5, 7, 1'b1, 2'd2); pe_in3 = 1'b1; t0_idx = 2'd2;
    mid();
    chk("add_comb_t1", t1[P0], 12);
    chk("add_busy_c0", 32'(busy[P1]), 0);
    nxt(); idle(); mid();
    chk("add_t1",      t1[P1], 12);
    chk("add_t1v",     32'(t1v[P1]), 1);
    chk("add_p0",      32'(p0[P1]), 1);
    chk("add_busy_c1", 32'(busy[P1]), 1);
    chk("add_t0v_c1",  32'(t0v[P1]), 0);
    nxt(); mid();
    chk("add_t0",      t0[P1], 12);
    chk("add_t0v",     32'(t0v[P1]), 1);
    chk("add_busy_c2", 32'(busy[P1]), 0);
    chk("add_t1v_c2",  32'(t1v[P1]), 0);

    // Write conflict
    nxt(); idle(); issue(OP_ADD, 'hA0, 'h0A, 1'b1, 2'd1); mid();
    nxt(); idle(); issue(OP_ADD, 'h11, 'h22, 1'b1, 2'd0); dffw(2'd1, 'h55); mid();
    chk("cf_pre", 32'(cerr[P1]), 0);
    nxt(); idle(); dffw(2'd3, 'h55); t0_idx = 2'd1; mid();
    chk("cf_set", 32'(cerr[P1]), 1);
    chk("cf_win", t0[P1], 'hAA);
    nxt(); idle(); t0_idx = 2'd0; out_sel = 1'b1; t1_idx = 2'd3; mid();
    chk("cf_alu_other", t0[P1], 'h33);
    chk("cf_dff_other", t1[P1], 'h55);
    chk("cf_dff_vld",   32'(t1v[P1]), 1);
    chk("cf_sticky",    32'(cerr[P1]), 1);

    // ctx_clear with three results in flight, ALU_PIPE=3
    for (int k = 0; k < 3; k++) begin
      nxt(); idle(); issue(OP_ADD, 32'(k + 1), 'h10, 1'b1, 2'(k));
    end
    nxt(); idle(); ctx_clear = 1'b1; issue(OP_ADD, 'h40, 1, 1'b1, 2'd3); dffw(2'd3, 'h77);
    mid();
    chk("clr_busy_pre", 32'(busy[P3]), 1);
    chk("clr_t1_pre",   t1[P3], 'h11);
    chk("clr_cerr_pre", 32'(cerr[P1]), 1);
    nxt(); idle(); t0_idx = 2'd0; out_sel = 1'b1; t1_idx = 2'd3; mid();
    chk("clr_busy",   32'(busy[P3]), 0);
    chk("clr_busy1",  32'(busy[P1]), 0);
    chk("clr_p0v",    32'(p0v[P3]), 0);
    chk("clr_r3v",    32'(t1v[P3]), 0);
    chk("clr_r0v",    32'(t0v[P3]), 0);
    chk("clr_r0v_p1", 32'(t0v[P1]), 0);
    chk("clr_cerr",   32'(cerr[P1]), 0);
    nxt(); t0_idx = 2'd1; mid();
    chk("clr_r1v", 32'(t0v[P3]), 0);
    nxt(); t0_idx = 2'd2; mid();
    chk("clr_r2v", 32'(t0v[P3]), 0);

    // Reset while results are in flight
    nxt(); idle(); issue(OP_ADD, 3, 4, 1'b1, 2'd2); dffw(2'd0, 'h99); mid();
    nxt(); idle(); rst_n = 1'b0; mid();
    chk("rf_busy_pre", 32'(busy[P3]), 1);
    nxt(); rst_n = 1'b1; t0_idx = 2'd2; mid();
    chk("rf_busy", 32'(busy[P3]), 0);
    chk("rf_t0",   t0[P1], 0);
    chk("rf_t0v",  32'(t0v[P1]), 0);
    chk("rf_t1",   t1[P1], 0);
    chk("rf_t1v",  32'(t1v[P3]), 0);
    chk("rf_p0v",  32'(p0v[P1]), 0);
    nxt(); t0_idx = 2'd0; mid();
    chk("rf_dff_t0",  t0[P1], 0);
    chk("rf_dff_t0v", 32'(t0v[P1]), 0);
    nxt(); nxt(); t0_idx = 2'd2; mid();
    chk("rf_nocommit", 32'(t0v[P3]), 0);

    // Out-of-range index, NUM_REGS=3
    for (int k = 0; k < 4; k++) begin
      nxt(); idle(); dffw(2'(k), 32'('h10 * (k + 1)));
    end
    nxt(); idle(); t0_idx = 2'd3; mid();
    chk("oor_t0",     t0[N3], 0);
    chk("oor_t0v",    32'(t0v[N3]), 0);
    chk("oor_4reg",   t0[P1], 'h40);
    chk("oor_4reg_v", 32'(t0v[P1]), 1);
    nxt(); t0_idx = 2'd0; out_sel = 1'b1; t1_idx = 2'd1; mid();
    chk("oor_r0", t0[N3], 'h10);
    chk("oor_r1", t1[N3], 'h20);
    nxt(); t0_idx = 2'd2; t1_idx = 2'd3; mid();
    chk("oor_r2",     t0[N3], 'h30);
    chk("oor_t1",     t1[N3], 0);
    chk("oor_t1v",    32'(t1v[N3]), 0);

    // Throughput, ALU_PIPE=0
    for (int k = 1; k <= 4; k++) begin
      nxt(); idle(); issue(OP_ADD, 32'(k), 1, 1'b1, 2'(k - 1)); mid();
      chk("tp_t1",  t1[P0], 32'(k + 1));
      chk("tp_t1v", 32'(t1v[P0]), 1);
    end
    for (int k = 0; k < 4; k++) begin
      nxt(); idle(); t0_idx = 2'(k); out_sel = 1'b1; t1_idx = 2'(k); mid();
      chk("tp_reg",   t0[P0], 32'(k + 2));
      chk("tp_reg_v", 32'(t0v[P0]), 1);
      chk("tp_reg_t1", t1[P0], 32'(k + 2));
    end

    // Other ALU operations on the combinational tail
    nxt(); idle(); issue(OP_SUB, 9, 3, 1'b0, 2'd0); mid();
    chk("op_sub", t1[P0], 6);
    issue(OP_LT, 3, 9, 1'b0, 2'd0); #1;
    chk("op_lt_res",  t1[P0], 1);
    chk("op_lt_pred", 32'(p0[P0]), 1);
    issue(OP_LT, 9, 3, 1'b0, 2'd0); #1;
    chk("op_ge_pred", 32'(p0[P0]), 0);
    issue(OP_MAC, 3, 4, 1'b0, 2'd0); pe_in2 = 5; #1;
    chk("op_mac", t1[P0], 17);
    nxt(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
